// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module   : instr_fetch_unit
// Brief    : PC holder and req/ack fetch stage feeding decoded fields to control
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    output logic        imem_req,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        pc_src,
    input  logic [31:0] branch_target,
    input  logic        exec_done,
    input  logic        halt,
    output logic [31:0] instr,
    output logic [3:0]  cond,
    output logic [1:0]  op,
    output logic [5:0]  funct,
    output logic [3:0]  rd,
    output logic [1:0]  sh,
    output logic        instr_valid,
    output logic [31:0] pc_plus8,
    output logic        fault
);

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        ISSUE  = 3'd2,
        HALTED = 3'd3,
        FAULT  = 3'd4
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [7:0]  wait_cnt;

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    state_next = halt ? HALTED : REQ;
            REQ: begin
                // an ack in the timeout cycle still completes the fetch
                if (imem_ack)
                    state_next = ISSUE;
                else if (wait_cnt == WAIT_LAST)
                    state_next = FAULT;
            end
            ISSUE: begin
                if (exec_done)
                    state_next = halt ? HALTED : REQ;
            end
            HALTED: begin
                if (!halt)
                    state_next = REQ;
            end
            FAULT:   state_next = FAULT;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            instr    <= 32'h0;
            wait_cnt <= 8'h0;
            fault    <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                REQ: begin
                    if (imem_ack) begin
                        instr    <= imem_rdata;
                        wait_cnt <= 8'h0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        fault    <= 1'b1;
                        wait_cnt <= 8'h0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'h1;
                    end
                end
                ISSUE: begin
                    if (exec_done)
                        pc <= pc_src ? (branch_target & 32'hFFFF_FFFC) : (pc + 32'd4);
                end
                default: ;
            endcase
        end
    end

    assign imem_addr   = pc;
    assign imem_req    = (state == REQ);
    assign instr_valid = (state == ISSUE);
    assign pc_plus8    = pc + 32'd8;

    assign cond  = instr[31:28];
    assign op    = instr[27:26];
    assign funct = instr[25:20];
    assign rd    = instr[15:12];
    assign sh    = instr[6:5];

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module   : tb_instr_fetch_unit
// Brief    : Directed plus randomized bench for instr_fetch_unit against a PC model
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    localparam int MAX_WAIT = 15;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        pc_src = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        exec_done = 1'b0;
    logic        halt = 1'b0;
    logic [31:0] instr;
    logic [3:0]  cond;
    logic [1:0]  op;
    logic [5:0]  funct;
    logic [3:0]  rd;
    logic [1:0]  sh;
    logic        instr_valid;
    logic [31:0] pc_plus8;
    logic        fault;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instr = 32'h0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_req(imem_req),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc_src(pc_src),
        .branch_target(branch_target), .exec_done(exec_done), .halt(halt),
        .instr(instr), .cond(cond), .op(op), .funct(funct), .rd(rd), .sh(sh),
        .instr_valid(instr_valid), .pc_plus8(pc_plus8), .fault(fault)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Release reset, check the single idle cycle, land in the first REQ cycle.
    task automatic release_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("idle_req", 32'(imem_req), 32'd0);
        chk("idle_valid", 32'(instr_valid), 32'd0);
        step();
        exp_pc = 32'h0;
    endtask

    // Entered in a REQ cycle; acks after 'delay' empty REQ cycles.
    task automatic fetch(input logic [31:0] w, input int delay);
        for (int i = 0; i < delay; i++) begin
            chk("req_wait", 32'(imem_req), 32'd1);
            chk("addr_wait", imem_addr, exp_pc);
            chk("fault_wait", 32'(fault), 32'd0);
            imem_rdata = $urandom;
            step();
        end
        chk("req_ack", 32'(imem_req), 32'd1);
        chk("addr_ack", imem_addr, exp_pc);
        imem_ack   = 1'b1;
        imem_rdata = w;
        step();
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        exp_instr  = w;
        chk("valid", 32'(instr_valid), 32'd1);
        chk("req_issue", 32'(imem_req), 32'd0);
        chk("instr", instr, w);
        chk("cond", 32'(cond), 32'(w[31:28]));
        chk("op", 32'(op), 32'(w[27:26]));
        chk("funct", 32'(funct), 32'(w[25:20]));
        chk("rd", 32'(rd), 32'(w[15:12]));
        chk("sh", 32'(sh), 32'(w[6:5]));
        chk("pc_plus8", pc_plus8, exp_pc + 32'd8);
        chk("fault_ok", 32'(fault), 32'd0);
    endtask

    // Entered in an ISSUE cycle; leaves the bench in the next REQ cycle.
    task automatic execute(input logic src, input logic [31:0] bt, input logic hlt, input int hold);
        for (int i = 0; i < hold; i++) begin
            imem_ack   = 1'($urandom_range(0, 1));
            imem_rdata = $urandom;
            step();
            chk("hold_valid", 32'(instr_valid), 32'd1);
            chk("hold_instr", instr, exp_instr);
            chk("hold_addr", imem_addr, exp_pc);
        end
        imem_ack      = 1'b0;
        exec_done     = 1'b1;
        pc_src        = src;
        branch_target = bt;
        halt          = hlt;
        step();
        exec_done = 1'b0;
        pc_src    = 1'b0;
        exp_pc    = src ? {bt[31:2], 2'b00} : exp_pc + 32'd4;
        chk("exit_valid", 32'(instr_valid), 32'd0);
        chk("next_addr", imem_addr, exp_pc);
        if (hlt) begin
            for (int i = 0; i < 2; i++) begin
                chk("halt_req", 32'(imem_req), 32'd0);
                exec_done = 1'b1;
                step();
                exec_done = 1'b0;
                chk("halt_addr", imem_addr, exp_pc);
            end
            halt = 1'b0;
            step();
        end
        chk("next_req", 32'(imem_req), 32'd1);
        chk("next_req_addr", imem_addr, exp_pc);
    endtask

    initial begin
        #2;
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        release_reset();

        fetch(32'hE3A0_1005, 1);
        chk("t1_cond", 32'(cond), 32'hE);
        chk("t1_op", 32'(op), 32'h0);
        chk("t1_funct", 32'(funct), 32'h3A);
        chk("t1_rd", 32'(rd), 32'h1);
        execute(1'b0, $urandom, 1'b0, 1);
        chk("t2_seq", imem_addr, 32'h4);

        fetch($urandom, 0);
        execute(1'b1, 32'h0000_0103, 1'b0, 0);
        chk("t2_branch", imem_addr, 32'h100);

        fetch($urandom, 2);
        execute(1'b1, 32'hFFFF_FFFF, 1'b0, 0);
        fetch($urandom, 0);
        chk("t3_plus8", pc_plus8, 32'h4);
        execute(1'b0, 32'h0, 1'b0, 2);
        chk("t3_wrap", imem_addr, 32'h0);

        // ack arriving in the very last REQ cycle must beat the timeout
        fetch($urandom, MAX_WAIT - 1);
        execute(1'b0, 32'h0, 1'b1, 1);

        for (int n = 0; n < 20; n++) begin
            fetch($urandom, int'($urandom_range(0, MAX_WAIT - 1)));
            execute(1'($urandom_range(0, 1)), $urandom, ($urandom_range(0, 3) == 0),
                    int'($urandom_range(0, 3)));
        end

        for (int i = 0; i < MAX_WAIT - 1; i++) begin
            chk("to_req", 32'(imem_req), 32'd1);
            chk("to_nofault", 32'(fault), 32'd0);
            step();
        end
        chk("to_last_req", 32'(imem_req), 32'd1);
        step();
        chk("to_fault", 32'(fault), 32'd1);
        chk("to_req_drop", 32'(imem_req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            imem_ack  = 1'b1;
            exec_done = 1'b1;
            step();
            chk("to_sticky", 32'(fault), 32'd1);
            chk("to_noreq", 32'(imem_req), 32'd0);
            chk("to_novalid", 32'(instr_valid), 32'd0);
        end
        imem_ack  = 1'b0;
        exec_done = 1'b0;
        rst = 1'b1;
        #1;
        chk("to_rst_clear", 32'(fault), 32'd0);
        release_reset();

        fetch($urandom, 0);
        execute(1'b1, 32'h0000_2000, 1'b0, 0);
        step();
        #3;
        rst = 1'b1;
        #1;
        chk("async_req", 32'(imem_req), 32'd0);
        chk("async_valid", 32'(instr_valid), 32'd0);
        chk("async_instr", instr, 32'h0);
        chk("async_addr", imem_addr, 32'h0);
        @(posedge clk);
        #1;
        rst        = 1'b0;
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        step();
        imem_ack = 1'b0;
        exp_pc   = 32'h0;
        chk("late_ack_instr", instr, 32'h0);
        chk("late_ack_req", 32'(imem_req), 32'd1);
        fetch($urandom, 1);
        execute(1'b0, 32'h0, 1'b0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
